matmul_host_loader: RTL and testbench
=====================================

Name: matmul_host_loader

Overview:
- Host-side initiator for the BRAM-backed 4x4 systolic matmul top. Drives its external BRAM port (addr/we/wdata/rdata, mem_sel) and its start_reg/clear_done_reg controls.
- Sequence per job:
  - accept 4 rows of A, then 4 rows of B, from an input valid/ready stream;
  - write the rows into BRAM A and BRAM B;
  - pulse start and wait for done;
  - read back 4 rows of C from BRAM C and emit them on an output valid/ready stream.

Parameters:
DWIDTH, 8, element width in bits
AWIDTH, 10, BRAM address width
MAT_SIZE, 4, rows per matrix; also elements per row
TIMEOUT_CYCLES, 1024, watchdog limit while waiting for done (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle pulse that begins a job; accepted only in IDLE
base_a / base_b / base_c  in  AWIDTH each  row-0 addresses; sampled at cmd_start
stride  in  8  row address stride for A, B and C; sampled at cmd_start
s_data  in  MAT_SIZE*DWIDTH  input row (A rows 0-3, then B rows 0-3)
s_valid  in  1  input row valid
s_ready  out  1  input row accepted when s_valid && s_ready
m_data  out  MAT_SIZE*DWIDTH  output C row
m_valid  out  1  output row valid
m_ready  in  1  downstream accepts the output row
bram_addr_ext  out  AWIDTH  address presented to all three external BRAM ports
bram_we_ext  out  MAT_SIZE  byte write enable; driven to A or B only
bram_wdata  out  MAT_SIZE*DWIDTH  write data
bram_rdata  in  MAT_SIZE*DWIDTH  read data for the memory selected by mem_sel; 1-cycle latency
mem_sel  out  2  memory select: 0=A, 1=B, 2=C
start_reg  out  1  start to the matmul
clear_done_reg  out  1  clear to the matmul
mm_done  in  1  matmul done level
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset values: state=IDLE; all outputs 0 (mem_sel=0, bram_we_ext=0, m_valid=0, s_ready=0, busy=0, err=0). All address and row counters 0.
- Reset asserted mid-job aborts immediately to IDLE. Any matmul already started is not cleared by this block.
- States and transitions:
  - IDLE: s_ready=0. cmd_start latches bases and stride, clears row=0, goes to LOAD_A. cmd_start outside IDLE is ignored.
  - LOAD_A: mem_sel=0, s_ready=1.
    - On handshake: bram_addr_ext=base_a+row*stride, bram_we_ext=4'b1111, bram_wdata=s_data, all registered so the write occurs the next cycle; row++.
    - After row 3: row=0, go to LOAD_B.
  - LOAD_B: same as LOAD_A with mem_sel=1 and base_b. After row 3 go to START.
  - START: start_reg=1 for exactly 1 cycle, then WAIT.
  - WAIT: start_reg=0. When mm_done=1, go to READ_ADDR with mem_sel=2 and row=0.
  - READ_ADDR: bram_addr_ext=base_c+row*stride, we=0, go to READ_DATA.
  - READ_DATA: capture bram_rdata into m_data, set m_valid=1, go to OUT.
  - OUT: hold m_data and m_valid stable until m_ready.
    - On handshake: m_valid=0, row++.
    - If the row just sent was row 3, go to CLEAR; otherwise go to READ_ADDR.
  - CLEAR: clear_done_reg=1 for 1 cycle, then IDLE.
- Throughput:
  - Load: 1 row per cycle when s_valid is held high.
  - Readback: 1 row per 3 cycles minimum.
- Latency: minimum from cmd_start to first m_valid = 8 load cycles + 1 (START) + mm_done wait + 2 cycles.
- Address arithmetic is modulo 2^AWIDTH; overflow wraps silently.
- bram_we_ext is 0 in every state except the cycle following a LOAD handshake.
- s_ready=0 outside LOAD_A and LOAD_B; extra input rows are back-pressured, not dropped.
- An mm_done already high on entry to WAIT is taken on the first WAIT cycle.

Optional Feature:
MATMUL_LOADER_TIMEOUT_EN
- Defined:
  - WAIT counts cycles from entry.
  - Reaching TIMEOUT_CYCLES without mm_done sets err=1 (sticky until reset) and goes to CLEAR without any readback. C rows are not emitted.
- Undefined: no counter; WAIT blocks indefinitely; err is tied to 0.

Test Plan:
- Basic job: bases A=0, B=16, C=32, stride=1; stream 8 rows; mm_done asserted 20 cycles after start_reg.
  - Required: writes at addresses 0-3 with mem_sel=0 and at 16-19 with mem_sel=1.
  - Required: exactly one start_reg pulse.
  - Required: reads at addresses 32-35; m_data equals the preloaded C rows in order; one clear_done_reg pulse; busy=0 afterwards.
- Stride and wrap: base_a=1022, stride=2 -> A writes at addresses 1022, 0, 2, 4.
- Backpressure: s_valid toggled 1/0 and m_ready held 0 for 5 cycles per row.
  - Required: no row lost or duplicated; m_data stays stable while m_valid=1 && m_ready=0.
- Reset mid-job: assert resetn=0 during LOAD_B row 2 -> all outputs 0 asynchronously; the next cmd_start restarts cleanly from LOAD_A.
- Ignored start: cmd_start pulsed during WAIT -> no state change and no second start_reg pulse.
- Timeout (feature defined, TIMEOUT_CYCLES=16, mm_done never asserted):
  - Required: err=1 after 16 WAIT cycles, then a clear_done_reg pulse, m_valid never asserted, return to IDLE.

Source files
------------

// File: rtl/matmul_host_loader.sv
// Host-side loader for the 4x4 systolic matmul: streams A/B rows into BRAM, starts the job,
// then reads C back onto an output stream. Optional done-watchdog: MATMUL_LOADER_TIMEOUT_EN.
module matmul_host_loader #(
   parameter int DWIDTH         = 8,
   parameter int AWIDTH         = 10,
   parameter int MAT_SIZE       = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       cmd_start,
   input  logic [AWIDTH-1:0]          base_a,
   input  logic [AWIDTH-1:0]          base_b,
   input  logic [AWIDTH-1:0]          base_c,
   input  logic [7:0]                 stride,
   input  logic [MAT_SIZE*DWIDTH-1:0] s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [MAT_SIZE*DWIDTH-1:0] m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [AWIDTH-1:0]          bram_addr_ext,
   output logic [MAT_SIZE-1:0]        bram_we_ext,
   output logic [MAT_SIZE*DWIDTH-1:0] bram_wdata,
   input  logic [MAT_SIZE*DWIDTH-1:0] bram_rdata,
   output logic [1:0]                 mem_sel,
   output logic                       start_reg,
   output logic                       clear_done_reg,
   input  logic                       mm_done,
   output logic                       busy,
   output logic                       err
);
   localparam int RW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;

   typedef enum logic [3:0] {
      IDLE, LOAD_A, LOAD_B, START, WAIT, READ_ADDR, READ_DATA, OUT, CLEAR
   } state_t;

   state_t            state;
   logic [RW-1:0]     row;
   logic [AWIDTH-1:0] ptr;
   logic [AWIDTH-1:0] base_b_q;
   logic [AWIDTH-1:0] base_c_q;
   logic [7:0]        stride_q;
   logic              last_row;
   logic              s_hs;
   logic [AWIDTH-1:0] ptr_next;

`ifdef MATMUL_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wcnt;
`else
   assign err = 1'b0;
`endif

   // ptr walks base + row*stride incrementally; AWIDTH-bit adds wrap silently.
   assign last_row = (row == RW'(MAT_SIZE - 1));
   assign s_hs     = s_valid && s_ready;
   assign ptr_next = ptr + AWIDTH'(stride_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         row            <= '0;
         ptr            <= '0;
         base_b_q       <= '0;
         base_c_q       <= '0;
         stride_q       <= '0;
         s_ready        <= 1'b0;
         m_valid        <= 1'b0;
         m_data         <= '0;
         bram_addr_ext  <= '0;
         bram_we_ext    <= '0;
         bram_wdata     <= '0;
         mem_sel        <= 2'd0;
         start_reg      <= 1'b0;
         clear_done_reg <= 1'b0;
         busy           <= 1'b0;
`ifdef MATMUL_LOADER_TIMEOUT_EN
         wcnt           <= '0;
         err            <= 1'b0;
`endif
      end else begin
         bram_we_ext    <= '0;
         start_reg      <= 1'b0;
         clear_done_reg <= 1'b0;
         case (state)
            IDLE: if (cmd_start) begin
               state    <= LOAD_A;
               ptr      <= base_a;
               base_b_q <= base_b;
               base_c_q <= base_c;
               stride_q <= stride;
               row      <= '0;
               mem_sel  <= 2'd0;
               s_ready  <= 1'b1;
               busy     <= 1'b1;
            end
            // mem_sel moves with each registered write so the final A write,
            // which lands in the first LOAD_B cycle, still targets BRAM A.
            LOAD_A, LOAD_B: if (s_hs) begin
               bram_addr_ext <= ptr;
               bram_we_ext   <= '1;
               bram_wdata    <= s_data;
               mem_sel       <= (state == LOAD_B) ? 2'd1 : 2'd0;
               ptr           <= ptr_next;
               row           <= row + 1'b1;
               if (last_row) begin
                  row <= '0;
                  if (state == LOAD_A) begin
                     state <= LOAD_B;
                     ptr   <= base_b_q;
                  end else begin
                     state     <= START;
                     s_ready   <= 1'b0;
                     start_reg <= 1'b1;
                  end
               end
            end
            START: begin
               state <= WAIT;
`ifdef MATMUL_LOADER_TIMEOUT_EN
               wcnt  <= '0;
`endif
            end
            WAIT: if (mm_done) begin
               state         <= READ_ADDR;
               mem_sel       <= 2'd2;
               row           <= '0;
               bram_addr_ext <= base_c_q;
               ptr           <= base_c_q + AWIDTH'(stride_q);
            end
`ifdef MATMUL_LOADER_TIMEOUT_EN
            else if (wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               err            <= 1'b1;
               clear_done_reg <= 1'b1;
               state          <= CLEAR;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
`endif
            READ_ADDR: state <= READ_DATA;
            READ_DATA: begin
               m_data  <= bram_rdata;
               m_valid <= 1'b1;
               state   <= OUT;
            end
            OUT: if (m_ready) begin
               m_valid <= 1'b0;
               row     <= row + 1'b1;
               if (last_row) begin
                  clear_done_reg <= 1'b1;
                  state          <= CLEAR;
               end else begin
                  bram_addr_ext <= ptr;
                  ptr           <= ptr_next;
                  state         <= READ_ADDR;
               end
            end
            CLEAR: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_host_loader.sv
// Directed bench for matmul_host_loader: BRAM and matmul-done behavioural models plus
// hand-derived expected addresses, rows and pulse counts.
module tb_matmul_host_loader;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cmd_start = 1'b0;
   logic [9:0]    base_a = '0, base_b = '0, base_c = '0;
   logic [7:0]    stride = '0;
   logic [W-1:0]  s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [9:0]    bram_addr_ext;
   logic [3:0]    bram_we_ext;
   logic [W-1:0]  bram_wdata;
   logic [W-1:0]  bram_rdata = '0;
   logic [1:0]    mem_sel;
   logic          start_reg, clear_done_reg;
   logic          mm_done = 1'b0;
   logic          busy, err;

   matmul_host_loader #(.DWIDTH(8), .AWIDTH(10), .MAT_SIZE(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .resetn(resetn), .cmd_start(cmd_start),
      .base_a(base_a), .base_b(base_b), .base_c(base_c), .stride(stride),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .bram_addr_ext(bram_addr_ext), .bram_we_ext(bram_we_ext), .bram_wdata(bram_wdata),
      .bram_rdata(bram_rdata), .mem_sel(mem_sel), .start_reg(start_reg),
      .clear_done_reg(clear_done_reg), .mm_done(mm_done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] cval(input logic [9:0] a);
      return {8'hC3, 6'd0, a, 8'h5A};
   endfunction

   // BRAM / matmul models
   logic [W-1:0] mem_a [1024];
   logic [W-1:0] mem_b [1024];
   logic [W-1:0] mem_c [1024];
   logic [9:0]   addr_s;
   logic [1:0]   sel_s;
   logic [1:0]   wl_sel  [64];
   logic [9:0]   wl_addr [64];
   logic [W-1:0] wl_data [64];
   int wr_n = 0, start_cnt = 0, clr_cnt = 0, mv_cnt = 0;
   int done_dly = 20;
   int dcnt = -1;

   always @(negedge clk) begin
      addr_s = bram_addr_ext;
      sel_s  = mem_sel;
      if (bram_we_ext != 4'd0) begin
         if (wr_n < 64) begin
            wl_sel[wr_n] = mem_sel; wl_addr[wr_n] = bram_addr_ext; wl_data[wr_n] = bram_wdata;
            wr_n++;
         end
         if (mem_sel == 2'd0) mem_a[bram_addr_ext] = bram_wdata;
         else if (mem_sel == 2'd1) mem_b[bram_addr_ext] = bram_wdata;
      end
      if (m_valid) mv_cnt++;
      if (start_reg) begin
         start_cnt++;
         if (done_dly >= 0) dcnt = done_dly;
      end else if (dcnt > 0) dcnt--;
      if (dcnt == 0) begin mm_done = 1'b1; dcnt = -1; end
      if (clear_done_reg) begin clr_cnt++; mm_done = 1'b0; dcnt = -1; end
   end

   always @(posedge clk)
      bram_rdata <= (sel_s == 2'd2) ? mem_c[addr_s] : (sel_s == 2'd1) ? mem_b[addr_s] : mem_a[addr_s];

   task automatic pulse_start();
      @(posedge clk); #1 cmd_start = 1'b1;
      @(posedge clk); #1 cmd_start = 1'b0;
   endtask

   task automatic feed(input logic [W-1:0] rows [8], input int nr, input bit tog);
      int n;
      for (int i = 0; i < nr; i++) begin
         if (tog) begin s_valid = 1'b0; @(posedge clk); #1; end
         s_valid = 1'b1; s_data = rows[i];
         n = 0;
         @(negedge clk);
         while (!s_ready && n < 50) begin @(negedge clk); n++; end
         chk($sformatf("feed%0d_ready", i), 32'(s_ready), 1);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic collect(input logic [9:0] bc, input logic [7:0] st, input int stall);
      int n;
      logic [W-1:0] e;
      for (int r = 0; r < 4; r++) begin
         n = 0;
         @(negedge clk);
         while (!m_valid && n < 200) begin @(negedge clk); n++; end
         chk($sformatf("c%0d_valid", r), 32'(m_valid), 1);
         e = cval(bc + 10'(r * st));
         chk($sformatf("c%0d_data", r), m_data, e);
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk($sformatf("c%0d_hold%0d", r, k), {m_data[30:0], m_valid}, {e[30:0], 1'b1});
         end
         m_ready = 1'b1;
         @(posedge clk); #1 m_ready = 1'b0;
      end
   endtask

   task automatic run_job(input int job, input logic [9:0] ba, bb, bc, input logic [7:0] st,
                          input bit tog, input int stall, input bit poke);
      int s0, c0, w0, n;
      logic [W-1:0] rows [8];
      logic [9:0]   ea;
      s0 = start_cnt; c0 = clr_cnt; w0 = wr_n;
      for (int i = 0; i < 8; i++)
         rows[i] = (i < 4) ? (32'hA000_0000 | (job << 8) | i) : (32'hB000_0000 | (job << 8) | (i - 4));
      base_a = ba; base_b = bb; base_c = bc; stride = st;
      pulse_start();
      feed(rows, 8, tog);
      // a ninth row must be held off, not taken
      s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      chk($sformatf("j%0d_extra_held", job), 32'(s_ready), 0);
      s_valid = 1'b0;
      if (poke) pulse_start();
      collect(bc, st, stall);
      n = 0;
      @(negedge clk);
      while (!clear_done_reg && n < 50) begin @(negedge clk); n++; end
      chk($sformatf("j%0d_clear", job), 32'(clear_done_reg), 1);
      repeat (2) @(negedge clk);
      chk($sformatf("j%0d_busy_end", job), 32'(busy), 0);
      chk($sformatf("j%0d_starts", job), 32'(start_cnt - s0), 1);
      chk($sformatf("j%0d_clears", job), 32'(clr_cnt - c0), 1);
      chk($sformatf("j%0d_nwrites", job), 32'(wr_n - w0), 8);
      for (int i = 0; i < 8; i++) begin
         ea = ((i < 4) ? ba : bb) + 10'((i % 4) * st);
         chk($sformatf("j%0d_w%0d", job, i), {wl_sel[w0+i], wl_addr[w0+i], wl_data[w0+i][19:0]},
             {(i < 4) ? 2'd0 : 2'd1, ea, rows[i][19:0]});
      end
   endtask

   initial begin
      logic [W-1:0] rows [8];
      int n;
      for (int a = 0; a < 1024; a++) mem_c[a] = cval(10'(a));
      for (int i = 0; i < 8; i++) rows[i] = 32'h5500_0000 | i;

      #12;
      chk("rst_ctl", 32'({busy, s_ready, m_valid, start_reg, clear_done_reg, err, mem_sel, bram_we_ext}), 0);
      chk("rst_addr", 32'(bram_addr_ext), 0);
      chk("rst_mdata", m_data, 0);
      #5 resetn = 1'b1;

      // basic job, cmd_start re-pulsed during WAIT must be ignored
      done_dly = 20;
      run_job(1, 10'd0, 10'd16, 10'd32, 8'd1, 1'b0, 0, 1'b1);
      chk("j1_err", 32'(err), 0);

      // stride/wrap; mm_done already high on WAIT entry
      done_dly = 0;
      run_job(2, 10'd1022, 10'd1020, 10'd1021, 8'd2, 1'b0, 0, 1'b0);

      // input toggling and output backpressure
      done_dly = 20;
      run_job(3, 10'd100, 10'd200, 10'd300, 8'd7, 1'b1, 5, 1'b0);

      // reset during LOAD_B row 2
      base_a = 10'd0; base_b = 10'd16; base_c = 10'd32; stride = 8'd1;
      pulse_start();
      feed(rows, 6, 1'b0);
      chk("mid_busy_pre", 32'({busy, mem_sel}), 32'({1'b1, 2'd1}));
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_ctl", 32'({busy, s_ready, m_valid, start_reg, clear_done_reg, err, mem_sel, bram_we_ext}), 0);
      #13 resetn = 1'b1;
      run_job(4, 10'd40, 10'd60, 10'd80, 8'd3, 1'b0, 1, 1'b0);

`ifdef MATMUL_LOADER_TIMEOUT_EN
      begin
         int mv0, c0;
         done_dly = -1;
         mv0 = mv_cnt; c0 = clr_cnt;
         pulse_start();
         feed(rows, 8, 1'b0);
         n = 0;
         while (!start_reg && n < 20) begin @(negedge clk); n++; end
         chk("to_start", 32'(start_reg), 1);
         n = 0;
         while (!err && n < 100) begin @(negedge clk); n++; end
         chk("to_err_cycles", 32'(n), 17);
         chk("to_clear", 32'(clear_done_reg), 1);
         repeat (2) @(negedge clk);
         chk("to_idle", 32'({busy, err}), 32'(2'b01));
         chk("to_no_mvalid", 32'(mv_cnt - mv0), 0);
         chk("to_one_clear", 32'(clr_cnt - c0), 1);
         #2 resetn = 1'b0;
         #1 chk("to_err_rst", 32'(err), 0);
         #10 resetn = 1'b1;
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
